// File: rtl/flag_pkg.sv
// Shared types for the carry/zero flag unit: ALU op encodings, flag pair
// and the carry-in select rule.
package flag_pkg;

    localparam int OPSEL_WIDTH = 3;

    typedef enum logic [OPSEL_WIDTH-1:0] {
        OP_ADC = 3'b000,
        OP_SBC = 3'b001,
        OP_ADD = 3'b010,
        OP_RLC = 3'b011,
        OP_AND = 3'b100,
        OP_SUB = 3'b101,
        OP_RRC = 3'b110,
        OP_NOP = 3'b111
    } opsel_e;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

    // Carry-in for the ALU; unused encodings drive a clean 0.
    function automatic logic cin_sel(opsel_e op, logic c);
        logic cin;
        case (op)
            OP_ADC, OP_SBC, OP_RLC, OP_RRC: cin = c;
            OP_SUB:                         cin = 1'b1;
            default:                        cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO shadow stack for flag pairs. Callers must only push when not full and
// only pop when not empty; out-of-range requests are ignored here as well.
module flag_stack
    import flag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  flags_t           din,
    output flags_t           dout,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    flags_t           mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign depth   = cnt_q;
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (do_push && cnt_q == CNT_W'(i))
                mem_q[i] <= din;
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cnt_q == CNT_W'(i + 1))
                dout = mem_q[i];
    end

endmodule

// File: rtl/carry_flag_unit.sv
// Architectural C/Z flags with ALU carry-in select, a shadow stack for
// interrupt entry/return, and sticky overflow/underflow error flags.
module carry_flag_unit
    import flag_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int OPSEL_W = 3,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPSEL_W-1:0] opsel,
    input  logic               alu_c_out,
    input  logic               alu_z_out,
    input  logic               flg_ld,
    input  logic               flg_set,
    input  logic               flg_clr,
    input  logic               flg_push,
    input  logic               flg_pop,
    input  logic               err_clr,
    output logic               c_to_alu,
    output logic               c_flag,
    output logic               z_flag,
    output logic [CNT_W-1:0]   depth,
    output logic               ovf,
    output logic               unf
);

    flags_t flags_q, flags_d;
    flags_t stk_top;
    logic   ovf_q, ovf_d, unf_q, unf_d;
    logic   stk_full, stk_empty;
    logic   both, push_ok, pop_ok, ovf_evt, unf_evt;

    assign both    = flg_push & flg_pop;
    assign push_ok = flg_push & ~flg_pop & ~stk_full;
    assign pop_ok  = flg_pop & ~flg_push & ~stk_empty;
    assign ovf_evt = both | (flg_push & ~flg_pop & stk_full);
    assign unf_evt = both | (flg_pop & ~flg_push & stk_empty);

    flag_stack #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (flags_q),
        .dout  (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // A successful restore overrides every live update in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stk_top;
        end else begin
            if (flg_clr)
                flags_d.c = 1'b0;
            else if (flg_set)
                flags_d.c = 1'b1;
            else if (flg_ld)
                flags_d.c = alu_c_out;
            if (flg_ld)
                flags_d.z = alu_z_out;
        end
        ovf_d = ovf_evt | (ovf_q & ~err_clr);
        unf_d = unf_evt | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign c_flag   = flags_q.c;
    assign z_flag   = flags_q.z;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign c_to_alu = cin_sel(opsel_e'(opsel), flags_q.c);

endmodule

// File: doc/carry_flag_unit.md
# carry_flag_unit

Parametrised carry/zero flag unit for the CPU datapath. It holds the architectural C and Z flags and selects the ALU carry-in from the registered C flag according to the ALU op select. It also provides a LIFO shadow stack that saves flags on interrupt entry and restores them on return. It sits between the control unit and the ALU, replacing the purely combinational carry-in select.

## Interface
- DEPTH, 4, shadow-stack entries (≥1)
- OPSEL_W, 3, ALU op-select width (fixed at 3 in this generation; the parameter exists for the package typedef)
- CNT_W, $clog2(DEPTH+1), derived width of stack occupancy

- clk  in  1  system clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- opsel  in  OPSEL_W  ALU operation select
- alu_c_out  in  1  ALU carry-out of current op
- alu_z_out  in  1  ALU zero result of current op
- flg_ld  in  1  load C and Z from alu_c_out/alu_z_out
- flg_set  in  1  set C (SEC)
- flg_clr  in  1  clear C (CLC)
- flg_push  in  1  save {C,Z} to shadow stack (interrupt entry)
- flg_pop  in  1  restore {C,Z} from shadow stack (RETI)
- err_clr  in  1  clear sticky error flags
- c_to_alu  out  1  ALU carry-in
- c_flag  out  1  registered C
- z_flag  out  1  registered Z
- depth  out  CNT_W  current stack occupancy
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

## Operation
- c_to_alu is combinational from opsel and registered C:
  - 000, 001, 011, 110 → c_flag
  - 010, 100 → 0
  - 101 → 1
  - 111 → 0 (never Z/X)
- C next-value priority: valid pop > flg_clr > flg_set > flg_ld > hold. flg_set together with flg_clr gives C=0.
- Z next-value priority: valid pop > flg_ld > hold.
- Push: writes the current registered {C,Z} (the pre-update value) to top; depth+1. A same-cycle ld/set/clr still updates the live flags.
- Push while depth==DEPTH: stack and depth unchanged, ovf←1. Live flag updates still apply.
- Pop while depth>0: live {C,Z} ← top; depth−1. Same-cycle ld/set/clr are ignored.
- Pop while depth==0: stack, depth and flags unchanged, ovf unaffected, unf←1. Same-cycle ld/set/clr do apply.
- flg_push and flg_pop in the same cycle: both ignored, stack unchanged, ovf←1 and unf←1. Live updates apply.
- err_clr clears ovf/unf. An error event in the same cycle wins (the flag stays 1).

## Timing
- All state updates on the rising clk edge; c_flag, z_flag, depth, ovf and unf change one cycle after the request.
- c_to_alu has zero-cycle latency from opsel and reflects the new C right after the updating edge. An ADDC issued in the cycle after flg_ld therefore sees the new carry.
- Pop-to-flag latency: 1 cycle. Push-to-depth latency: 1 cycle.
- Reset (asynchronous, any time, including mid-push/pop): c_flag=0, z_flag=0, depth=0, ovf=0, unf=0, stack contents don't-care. c_to_alu is then 1 only for opsel 101.
- Deassertion of rst_n is synchronised externally; the first update is the first edge with rst_n=1.

## Structure
- Package flag_pkg:
  - opsel_e enum with 8 encodings
  - flags_t packed struct {c, z}
  - function cin_sel(opsel_e, logic c)
- Sub-module flag_stack (parameter DEPTH, data flags_t):
  - LIFO register array plus pointer
  - ports: push, pop, din, dout(top), depth, full, empty
- carry_flag_unit handles priority, error logic and c_to_alu.

## Test plan
- Reset with opsel sweep 000–111 → c_flag=0, z_flag=0, depth=0; c_to_alu=1 only at 101.
- flg_ld with alu_c_out=1, alu_z_out=1 → next cycle c_flag=1, z_flag=1. Then opsel 000 → c_to_alu=1, opsel 010 → 0, opsel 111 → 0.
- C=0, then flg_set & flg_clr together → C=0. flg_set alone → C=1. flg_set & flg_ld with alu_c_out=0 → C=1.
- C=1/Z=1, push; next cycle ld C=0/Z=0; then pop with simultaneous flg_clr → C=1, Z=1, depth 1→0.
- DEPTH=4, five pushes with distinct flags → depth=4, ovf=1 after the fifth. Five pops → fourth pop restores the first-pushed value, fifth sets unf and leaves flags unchanged. err_clr → ovf=unf=0.
- Depth=2, rst_n dropped mid-cycle between edges → all outputs zero immediately, before the next edge. A subsequent pop → unf=1.
